// File: rtl/dutmem_dp.sv
// ---------------------------------------------------------------------------
// dutmem_dp
//   Simple dual-port behavioural RAM for DUT wrappers: one write port with
//   byte-lane enables, one read port with 1- or 2-cycle latency, one clock.
//   After reset an optional clear sequencer zeroes every word before the
//   ports go live (init_done=1).
//
// Ports
//   clk        clock, everything on posedge
//   rstn       asynchronous active-low reset (does not touch array contents)
//   init_done  1 = clear finished, ports serviced
//   wce        write enable
//   waddr      write address
//   wbe        byte-lane enables, bit i covers data[i*BWIDTH +: BWIDTH]
//   wdata      write data
//   rce        read enable
//   raddr      read address
//   rdata      read data, holds its value between results
//   rvalid     one-cycle pulse, rdata is the result of a read RDLAT cycles ago
// ---------------------------------------------------------------------------
module dutmem_dp #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 10,
  parameter int DEPTH    = 1 << AWIDTH,
  parameter int BWIDTH   = 8,
  parameter int RDLAT    = 1,
  parameter int WFIRST   = 1,
  parameter int INIT_CLR = 1,
  localparam int NBE     = DWIDTH / BWIDTH
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              init_done,
  input  logic              wce,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [NBE-1:0]    wbe,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              rce,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata,
  output logic              rvalid
);

  typedef enum logic [0:0] {
    ST_CLR = 1'b0,
    ST_RUN = 1'b1
  } state_t;

  // One extra bit so DEPTH == 2^AWIDTH is representable in the range compare.
  localparam logic [AWIDTH:0]   DEPTH_X   = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

  // Merge new lanes over an old word according to the byte enables.
  function automatic logic [DWIDTH-1:0] merge_lanes(
    input logic [DWIDTH-1:0] old_w,
    input logic [DWIDTH-1:0] new_w,
    input logic [NBE-1:0]    be
  );
    logic [DWIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < NBE; i++) begin
      if (be[i]) begin
        res[i*BWIDTH +: BWIDTH] = new_w[i*BWIDTH +: BWIDTH];
      end else begin
        res[i*BWIDTH +: BWIDTH] = old_w[i*BWIDTH +: BWIDTH];
      end
    end
    return res;
  endfunction

  logic [DWIDTH-1:0] mem_r [DEPTH];

  state_t            state_r;
  state_t            state_nxt_s;
  logic [AWIDTH-1:0] clr_cnt_r;
  logic [AWIDTH-1:0] clr_cnt_nxt_s;
  logic              clr_we_s;
  logic              init_done_r;

  logic              wr_inr_s;
  logic              rd_inr_s;
  logic              wr_en_s;
  logic              rd_en_s;
  logic [DWIDTH-1:0] wr_word_s;
  logic [DWIDTH-1:0] rd_word_s;
  logic [DWIDTH-1:0] rd_data_s;

  logic              rv1_r;
  logic [DWIDTH-1:0] rd1_r;

  // Clear sequencer / run state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= ST_CLR;
      clr_cnt_r   <= '0;
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      clr_cnt_r   <= clr_cnt_nxt_s;
      init_done_r <= (state_nxt_s == ST_RUN);
    end
  end

  // Next-state logic: walk clr_cnt over 0..DEPTH-1, or leave CLR at once
  // when no clear is wanted. The clear write is held off while rstn is low
  // so reset itself never modifies the array.
  always_comb begin
    state_nxt_s   = state_r;
    clr_cnt_nxt_s = clr_cnt_r;
    clr_we_s      = 1'b0;
    case (state_r)
      ST_CLR: begin
        if (INIT_CLR != 0) begin
          clr_we_s = rstn;
          if (clr_cnt_r == LAST_ADDR) begin
            state_nxt_s = ST_RUN;
          end else begin
            clr_cnt_nxt_s = clr_cnt_r + 1'b1;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_RUN: begin
        state_nxt_s = ST_RUN;
      end
      default: begin
        state_nxt_s   = ST_CLR;
        clr_cnt_nxt_s = '0;
      end
    endcase
  end

  // Port qualification, write merge and read-data selection (incl. bypass).
  always_comb begin
    wr_inr_s  = ({1'b0, waddr} < DEPTH_X);
    rd_inr_s  = ({1'b0, raddr} < DEPTH_X);
    wr_en_s   = init_done_r && wce && wr_inr_s;
    rd_en_s   = init_done_r && rce;
    wr_word_s = merge_lanes(mem_r[waddr], wdata, wbe);
    rd_word_s = mem_r[raddr];
    if (!rd_inr_s) begin
      rd_data_s = '0;
    end else if ((WFIRST != 0) && wr_en_s && (waddr == raddr)) begin
      rd_data_s = wr_word_s;
    end else begin
      rd_data_s = rd_word_s;
    end
  end

  // Array update: the clear sequencer and port writes never overlap in time.
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      mem_r[clr_cnt_r] <= '0;
    end else if (wr_en_s) begin
      mem_r[waddr] <= wr_word_s;
    end
  end

  // First read stage; data register only loads on a read so it holds otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rv1_r <= 1'b0;
      rd1_r <= '0;
    end else begin
      rv1_r <= rd_en_s;
      if (rd_en_s) begin
        rd1_r <= rd_data_s;
      end
    end
  end

  generate
    if (RDLAT == 2) begin : g_lat2
      logic              rv2_r;
      logic [DWIDTH-1:0] rd2_r;

      // Extra output register stage for two-cycle latency.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          rv2_r <= 1'b0;
          rd2_r <= '0;
        end else begin
          rv2_r <= rv1_r;
          if (rv1_r) begin
            rd2_r <= rd1_r;
          end
        end
      end

      assign rvalid = rv2_r;
      assign rdata  = rd2_r;
    end else begin : g_lat1
      assign rvalid = rv1_r;
      assign rdata  = rd1_r;
    end
  endgenerate

  assign init_done = init_done_r;

endmodule

// File: tb/tb_dutmem_dp.sv
// ---------------------------------------------------------------------------
// tb_dutmem_dp
//   Scoreboard bench for dutmem_dp. Three instances share one stimulus bus:
//     A: DEPTH=16, RDLAT=1, WFIRST=1, INIT_CLR=1
//     B: DEPTH=16, RDLAT=2, WFIRST=0, INIT_CLR=1
//     C: AWIDTH=4, DEPTH=12, RDLAT=1, WFIRST=1, INIT_CLR=1
//   A fourth (D: INIT_CLR=0) only checks init_done timing.
//   Each read pushes hand-computed expected data and the cycle its result
//   must appear; a monitor pops on every rvalid pulse.
// ---------------------------------------------------------------------------
module tb_dutmem_dp;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wce;
  logic [9:0]  waddr;
  logic [3:0]  wbe;
  logic [31:0] wdata;
  logic        rce;
  logic [9:0]  raddr;

  logic        id_a, id_b, id_c, id_d;
  logic        rv_a, rv_b, rv_c, rv_d;
  logic [31:0] rd_a, rd_b, rd_c, rd_d;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t        q [3][$];
  exp_t        mon_e;
  logic [2:0]  rv_v;
  logic [31:0] rd_v [3];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign rv_v     = {rv_c, rv_b, rv_a};
  assign rd_v[0]  = rd_a;
  assign rd_v[1]  = rd_b;
  assign rd_v[2]  = rd_c;

  dutmem_dp #(.DEPTH(16), .RDLAT(1), .WFIRST(1), .INIT_CLR(1)) u_a (
    .clk(clk), .rstn(rstn), .init_done(id_a),
    .wce(wce), .waddr(waddr), .wbe(wbe), .wdata(wdata),
    .rce(rce), .raddr(raddr), .rdata(rd_a), .rvalid(rv_a)
  );

  dutmem_dp #(.DEPTH(16), .RDLAT(2), .WFIRST(0), .INIT_CLR(1)) u_b (
    .clk(clk), .rstn(rstn), .init_done(id_b),
    .wce(wce), .waddr(waddr), .wbe(wbe), .wdata(wdata),
    .rce(rce), .raddr(raddr), .rdata(rd_b), .rvalid(rv_b)
  );

  dutmem_dp #(.AWIDTH(4), .DEPTH(12), .RDLAT(1), .WFIRST(1), .INIT_CLR(1)) u_c (
    .clk(clk), .rstn(rstn), .init_done(id_c),
    .wce(wce), .waddr(waddr[3:0]), .wbe(wbe), .wdata(wdata),
    .rce(rce), .raddr(raddr[3:0]), .rdata(rd_c), .rvalid(rv_c)
  );

  dutmem_dp #(.DEPTH(16), .RDLAT(1), .WFIRST(1), .INIT_CLR(0)) u_d (
    .clk(clk), .rstn(rstn), .init_done(id_d),
    .wce(1'b0), .waddr(10'd0), .wbe(4'd0), .wdata(32'd0),
    .rce(1'b0), .raddr(10'd0), .rdata(rd_d), .rvalid(rv_d)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Monitor: every rvalid pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rv_v[k]) begin
        if (q[k].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid dut%0d: got rvalid=1 data=%h, required no pending read",
                   k, rd_v[k]);
        end else begin
          mon_e = q[k].pop_front();
          chk($sformatf("rdata_dut%0d", k), rd_v[k], mon_e.d);
          chk($sformatf("rvalid_cycle_dut%0d", k), 32'(cyc), 32'(mon_e.c));
        end
      end
    end
  end

  // One cycle of port traffic; called at a negedge. ea/eb/ec are the
  // expected read results for instances A, B, C.
  task automatic op(input logic we, input int wa, input logic [3:0] be,
                    input logic [31:0] wd, input logic re, input int ra,
                    input logic [31:0] ea, input logic [31:0] eb,
                    input logic [31:0] ec);
    wce   = we;
    waddr = 10'(wa);
    wbe   = be;
    wdata = wd;
    rce   = re;
    raddr = 10'(ra);
    if (re) begin
      q[0].push_back('{d: ea, c: cyc + 1});
      q[1].push_back('{d: eb, c: cyc + 2});
      q[2].push_back('{d: ec, c: cyc + 1});
    end
    @(negedge clk);
    wce = 1'b0;
    rce = 1'b0;
  endtask

  // Release reset and follow the clear. pulse_at>0 re-asserts rstn after
  // that many edges; do_gate attempts a write+read of addr 2 during clear.
  task automatic run_clear(input int pulse_at, input bit do_gate);
    rstn = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      if (do_gate && i == 5) begin
        wce   = 1'b1;
        waddr = 10'd2;
        wbe   = 4'hF;
        wdata = 32'h0000_0055;
        rce   = 1'b1;
        raddr = 10'd2;
      end
      @(negedge clk);
      wce = 1'b0;
      rce = 1'b0;
      chk($sformatf("init_done_dcba_edge%0d", i), {28'd0, id_d, id_c, id_b, id_a},
          {28'd0, (i >= 1), (i >= 12), (i >= 16), (i >= 16)});
      if (i == pulse_at) begin
        rstn = 1'b0;
        @(negedge clk);
        chk("midclear_reset_init_done", {28'd0, id_d, id_c, id_b, id_a}, 32'd0);
        return;
      end
    end
  endtask

  logic [31:0] tab [12];

  initial begin
    rstn  = 1'b0;
    wce   = 1'b0;
    waddr = 10'd0;
    wbe   = 4'd0;
    wdata = 32'd0;
    rce   = 1'b0;
    raddr = 10'd0;
    tab = '{32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 32'hAA22_CC44,
            32'h0000_0000, 32'h0000_FFFF, 32'h0000_0000, 32'h0000_0000,
            32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

    repeat (3) @(negedge clk);
    chk("reset_init_done", {28'd0, id_d, id_c, id_b, id_a}, 32'd0);
    chk("reset_rvalid", {28'd0, rv_d, rv_v}, 32'd0);
    chk("reset_rdata_a", rd_a, 32'd0);
    chk("reset_rdata_b", rd_b, 32'd0);
    chk("reset_rdata_c", rd_c, 32'd0);

    // Full clear, then reset again and abort a clear at edge 7, then a
    // full clear with a gated write attempt to addr 2.
    run_clear(0, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    run_clear(7, 1'b0);
    run_clear(0, 1'b1);

    // Every word reads zero after the clear (C: 12..15 are out of range -> 0).
    for (int a = 0; a < 16; a++) begin
      op(1'b0, 0, 4'h0, 32'd0, 1'b1, a, 32'd0, 32'd0, 32'd0);
    end

    // Byte enables.
    op(1'b1, 3, 4'hF, 32'hAABB_CCDD, 1'b0, 0, 32'd0, 32'd0, 32'd0);
    op(1'b1, 3, 4'b0101, 32'h1122_3344, 1'b0, 0, 32'd0, 32'd0, 32'd0);
    op(1'b0, 0, 4'h0, 32'd0, 1'b1, 3, 32'hAA22_CC44, 32'hAA22_CC44, 32'hAA22_CC44);

    // Same-edge collision on addr 5 (holds 0).
    op(1'b1, 5, 4'h3, 32'hFFFF_FFFF, 1'b1, 5, 32'h0000_FFFF, 32'h0000_0000, 32'h0000_FFFF);
    op(1'b0, 0, 4'h0, 32'd0, 1'b1, 5, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF);

    // Back-to-back reads of 0,1,2; the monitor checks the arrival cycles.
    op(1'b1, 0, 4'hF, 32'h0101_0101, 1'b0, 0, 32'd0, 32'd0, 32'd0);
    op(1'b1, 1, 4'hF, 32'h0202_0202, 1'b0, 0, 32'd0, 32'd0, 32'd0);
    op(1'b1, 2, 4'hF, 32'h0303_0303, 1'b0, 0, 32'd0, 32'd0, 32'd0);
    for (int a = 0; a < 3; a++) begin
      op(1'b0, 0, 4'h0, 32'd0, 1'b1, a, tab[a], tab[a], tab[a]);
    end
    repeat (3) @(negedge clk);
    chk("hold_rvalid", {29'd0, rv_v}, 32'd0);
    chk("hold_rdata_a", rd_a, 32'h0303_0303);
    chk("hold_rdata_b", rd_b, 32'h0303_0303);
    chk("hold_rdata_c", rd_c, 32'h0303_0303);

    // Address 13: valid for A/B, out of range for C.
    op(1'b1, 13, 4'hF, 32'hDEAD_BEEF, 1'b0, 0, 32'd0, 32'd0, 32'd0);
    op(1'b0, 0, 4'h0, 32'd0, 1'b1, 13, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd0);
    for (int a = 0; a < 12; a++) begin
      op(1'b0, 0, 4'h0, 32'd0, 1'b1, a, tab[a], tab[a], tab[a]);
    end
    op(1'b0, 0, 4'h0, 32'd0, 1'b1, 3, 32'hAA22_CC44, 32'hAA22_CC44, 32'hAA22_CC44);

    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("pending_reads_dut%0d", k), 32'(q[k].size()), 32'd0);
    end
    chk("final_hold_a", rd_a, 32'hAA22_CC44);
    chk("final_hold_b", rd_b, 32'hAA22_CC44);
    chk("final_hold_c", rd_c, 32'hAA22_CC44);
    chk("final_d_idle", {rd_d[30:0], rv_d}, 32'd0);
    chk("final_init_done", {28'd0, id_d, id_c, id_b, id_a}, 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1);
  end

endmodule
